// File: rtl/clock_pkg.sv
// Shared definitions for the clock tick scheduler.
// Holds the FSM state encoding, the default timing constants and a helper
// that sizes modulo counters from their modulus.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAST = 2'd2
    } state_e;

    localparam int DIV_1K_DEF     = 100000;
    localparam int MS_PER_SEC_DEF = 1000;
    localparam int FAST_MS_DEF    = 100;
    localparam int BLINK_MS_DEF   = 250;

    // Counter width for modulus n; a modulus of 1 still needs one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Generic modulo-N counter with enable and synchronous clear.
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - asynchronous active-low reset
//   clr_i   - synchronous clear to 0 (has priority over en_i)
//   en_i    - advance by one, wrapping N-1 -> 0
//   cnt_o   - current count
//   wrap_o  - high while enabled at N-1, i.e. on the cycle the counter wraps
module mod_counter
    import clock_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic                    en_i,
    output logic [cnt_width(N)-1:0] cnt_o,
    output logic                    wrap_o
);

    localparam int            W    = cnt_width(N);
    localparam logic [W-1:0]  LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap_o = en_i & (cnt_q == LAST);
    assign cnt_o  = cnt_q;

    // Next count: clear, wrap at N-1, increment, or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Tick scheduler for a digital clock: derives a millisecond strobe from the
// system clock, a display scan select, a setting-mode blink wave, and a
// seconds-advance strobe whose rate depends on the STOP/RUN/FAST state.
// Ports:
//   clk_i       - system clock, rising edge
//   reset       - asynchronous active-low reset
//   start_i     - pulse, STOP -> RUN
//   stop_i      - pulse, RUN/FAST -> STOP (wins over start_i)
//   fast_i      - level, selects FAST while counting
//   tick_1k_o   - one-cycle millisecond strobe
//   sec_tick_o  - one-cycle seconds-advance strobe
//   blink_o     - blink square wave
//   scan_sel_o  - rotating digit select 0..3
//   state_o     - current state (STOP=0, RUN=1, FAST=2)
// FAST_MS must not exceed MS_PER_SEC: both rates share one ms counter.
module tick_scheduler
    import clock_pkg::*;
#(
    parameter int DIV_1K     = DIV_1K_DEF,
    parameter int MS_PER_SEC = MS_PER_SEC_DEF,
    parameter int FAST_MS    = FAST_MS_DEF,
    parameter int BLINK_MS   = BLINK_MS_DEF
) (
    input  logic       clk_i,
    input  logic       reset,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       fast_i,
    output logic       tick_1k_o,
    output logic       sec_tick_o,
    output logic       blink_o,
    output logic [1:0] scan_sel_o,
    output logic [1:0] state_o
);

    localparam int                PRE_W     = cnt_width(DIV_1K);
    localparam int                BLK_W     = cnt_width(BLINK_MS);
    localparam int                MS_W      = cnt_width(MS_PER_SEC);
    localparam logic [MS_W-1:0]   FAST_LAST = MS_W'(FAST_MS - 1);

    state_e            state_q;
    state_e            state_d;
    logic              tick_q;
    logic              sec_q;
    logic              sec_d;
    logic              blink_q;
    logic [1:0]        scan_q;

    logic [PRE_W-1:0]  pre_cnt_s;
    logic              pre_wrap_s;
    logic [BLK_W-1:0]  blink_cnt_s;
    logic              blink_wrap_s;
    logic [MS_W-1:0]   ms_cnt_s;
    logic              ms_wrap_s;
    logic              ms_clr_s;
    logic              fast_wrap_s;
    logic              state_chg_s;
    logic              unused_s;

    // Only the wrap strobes of these two counters matter here
    assign unused_s = ^{pre_cnt_s, blink_cnt_s};

    mod_counter #(.N(DIV_1K)) u_prescaler (
        .clk_i  (clk_i),
        .rst_ni (reset),
        .clr_i  (1'b0),
        .en_i   (1'b1),
        .cnt_o  (pre_cnt_s),
        .wrap_o (pre_wrap_s)
    );

    mod_counter #(.N(BLINK_MS)) u_blink_cnt (
        .clk_i  (clk_i),
        .rst_ni (reset),
        .clr_i  (1'b0),
        .en_i   (pre_wrap_s),
        .cnt_o  (blink_cnt_s),
        .wrap_o (blink_wrap_s)
    );

    mod_counter #(.N(MS_PER_SEC)) u_ms_cnt (
        .clk_i  (clk_i),
        .rst_ni (reset),
        .clr_i  (ms_clr_s),
        .en_i   (pre_wrap_s),
        .cnt_o  (ms_cnt_s),
        .wrap_o (ms_wrap_s)
    );

    // FAST shares the ms counter and wraps it early by clearing it
    assign fast_wrap_s = pre_wrap_s & (ms_cnt_s == FAST_LAST);
    assign state_chg_s = (state_d != state_q);

    // State register
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            state_q <= ST_STOP;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop_i has priority over everything else
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: begin
                if (start_i && !stop_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d = ST_STOP;
                end else if (fast_i) begin
                    state_d = ST_FAST;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FAST: begin
                if (stop_i) begin
                    state_d = ST_STOP;
                end else if (!fast_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_FAST;
                end
            end
            default: state_d = ST_STOP;
        endcase
    end

    // State-dependent ms counter control and seconds strobe; any state
    // change clears the interval and suppresses the strobe
    always_comb begin
        ms_clr_s = 1'b1;
        sec_d    = 1'b0;
        case (state_q)
            ST_RUN: begin
                ms_clr_s = state_chg_s;
                sec_d    = ms_wrap_s & ~state_chg_s;
            end
            ST_FAST: begin
                ms_clr_s = state_chg_s | fast_wrap_s;
                sec_d    = fast_wrap_s & ~state_chg_s;
            end
            default: begin
                ms_clr_s = 1'b1;
                sec_d    = 1'b0;
            end
        endcase
    end

    // Output registers; scan select advances the cycle after each ms strobe
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            tick_q  <= 1'b0;
            sec_q   <= 1'b0;
            blink_q <= 1'b0;
            scan_q  <= 2'd0;
        end else begin
            tick_q  <= pre_wrap_s;
            sec_q   <= sec_d;
            blink_q <= blink_q ^ blink_wrap_s;
            scan_q  <= scan_q + {1'b0, tick_q};
        end
    end

    assign tick_1k_o  = tick_q;
    assign sec_tick_o = sec_q;
    assign blink_o    = blink_q;
    assign scan_sel_o = scan_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler with DIV_1K=4, MS_PER_SEC=10,
// FAST_MS=2, BLINK_MS=5. Cycle n is the value after the n-th rising edge
// following reset release. The stimulus pushes hand-computed event cycles
// (ms ticks with scan/blink values, seconds strobes, state changes);
// a negedge monitor pops and compares whenever the DUT shows an event.
module tb_tick_scheduler;

    localparam int DIV = 4;
    localparam int MSS = 10;
    localparam int FMS = 2;
    localparam int BMS = 5;

    logic       clk_i   = 1'b0;
    logic       reset   = 1'b0;
    logic       start_i = 1'b0;
    logic       stop_i  = 1'b0;
    logic       fast_i  = 1'b0;
    logic       tick_1k_o;
    logic       sec_tick_o;
    logic       blink_o;
    logic [1:0] scan_sel_o;
    logic [1:0] state_o;

    typedef struct {int cyc; int scan; int blink;} tick_t;
    typedef struct {int cyc; int st;} st_t;

    tick_t tick_q[$];
    int    sec_q[$];
    st_t   st_q[$];
    tick_t tk;
    st_t   se;
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    logic [1:0] last_state = 2'd0;

    tick_scheduler #(
        .DIV_1K(DIV), .MS_PER_SEC(MSS), .FAST_MS(FMS), .BLINK_MS(BMS)
    ) dut (
        .clk_i      (clk_i),
        .reset      (reset),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .fast_i     (fast_i),
        .tick_1k_o  (tick_1k_o),
        .sec_tick_o (sec_tick_o),
        .blink_o    (blink_o),
        .scan_sel_o (scan_sel_o),
        .state_o    (state_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected ms ticks k=1..n: cycle DIV*k, scan (k-1)%4, blink toggles on every BMS-th tick
    task automatic push_ticks(input int n);
        for (int k = 1; k <= n; k++) begin
            tick_t t;
            t.cyc   = DIV * k;
            t.scan  = (k - 1) % 4;
            t.blink = (k / BMS) % 2;
            tick_q.push_back(t);
        end
    endtask

    task automatic push_state(input int c, input int s);
        st_t e;
        e.cyc = c;
        e.st  = s;
        st_q.push_back(e);
    endtask

    task automatic wait_to(input int n);
        int g = 0;
        do begin
            @(negedge clk_i);
            g++;
        end while (cyc != n && g < 2000);
        if (cyc != n) check("wait_timeout", cyc, n);
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_tick"},  int'(tick_1k_o),  0);
        check({tag, "_sec"},   int'(sec_tick_o), 0);
        check({tag, "_blink"}, int'(blink_o),    0);
        check({tag, "_scan"},  int'(scan_sel_o), 0);
        check({tag, "_state"}, int'(state_o),    0);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_ticks_left"},  tick_q.size(), 0);
        check({tag, "_secs_left"},   sec_q.size(),  0);
        check({tag, "_states_left"}, st_q.size(),   0);
    endtask

    // Monitor: pop and compare on every observed event
    always @(negedge clk_i) begin
        if (!reset) begin
            last_state = 2'd0;
        end else begin
            if (tick_1k_o) begin
                if (tick_q.size() == 0) begin
                    check("unexpected_tick", cyc, -1);
                end else begin
                    tk = tick_q.pop_front();
                    check("tick_cycle", cyc, tk.cyc);
                    check("tick_scan",  int'(scan_sel_o), tk.scan);
                    check("tick_blink", int'(blink_o),    tk.blink);
                end
            end
            if (sec_tick_o) begin
                if (sec_q.size() == 0) check("unexpected_sec", cyc, -1);
                else                   check("sec_cycle", cyc, sec_q.pop_front());
            end
            if (state_o != last_state) begin
                if (st_q.size() == 0) begin
                    check("unexpected_state", int'(state_o), -1);
                end else begin
                    se = st_q.pop_front();
                    check("state_cycle", cyc, se.cyc);
                    check("state_value", int'(state_o), se.st);
                end
                last_state = state_o;
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk_i);
        check_outputs_reset("por");

        // Epoch 1 expectations
        push_ticks(66);
        sec_q = '{60, 68, 76, 84, 124, 200, 256, 264};
        push_state(23, 1);  push_state(63, 2);  push_state(87, 1);
        push_state(154, 0); push_state(161, 1); push_state(211, 0);
        push_state(231, 1); push_state(251, 2);
        reset = 1'b1;

        wait_to(22);  start_i = 1'b1; @(negedge clk_i); start_i = 1'b0;
        wait_to(62);  fast_i  = 1'b1;
        wait_to(86);  fast_i  = 1'b0;
        // Stop after 7 ms of RUN, then restart: full interval expected
        wait_to(153); stop_i  = 1'b1; @(negedge clk_i); stop_i  = 1'b0;
        wait_to(160); start_i = 1'b1; @(negedge clk_i); start_i = 1'b0;
        // start+stop together in RUN -> STOP; in STOP -> no change
        wait_to(210); start_i = 1'b1; stop_i = 1'b1; @(negedge clk_i); start_i = 1'b0; stop_i = 1'b0;
        wait_to(220); start_i = 1'b1; stop_i = 1'b1; @(negedge clk_i); start_i = 1'b0; stop_i = 1'b0;
        wait_to(224); stop_i  = 1'b1; @(negedge clk_i); stop_i  = 1'b0;
        wait_to(230); start_i = 1'b1; @(negedge clk_i); start_i = 1'b0;
        wait_to(240); start_i = 1'b1; @(negedge clk_i); start_i = 1'b0;
        wait_to(250); fast_i  = 1'b1;

        // One-cycle reset in the middle of FAST
        wait_to(266);
        reset = 1'b0;
        #1;
        check_outputs_reset("midrst");
        check_drained("epoch1");
        fast_i = 1'b0;
        @(negedge clk_i);

        // Epoch 2: restart from zero, then FAST -> STOP
        push_ticks(10);
        sec_q.push_back(12);
        push_state(3, 1); push_state(7, 2); push_state(14, 0);
        reset = 1'b1;
        wait_to(2);  start_i = 1'b1; @(negedge clk_i); start_i = 1'b0;
        wait_to(6);  fast_i  = 1'b1;
        wait_to(13); stop_i  = 1'b1; fast_i = 1'b0; @(negedge clk_i); stop_i = 1'b0;
        wait_to(42);
        check_drained("epoch2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter DIV_1K, default 100000: system clocks per millisecond tick.
REQ-002 Parameter MS_PER_SEC, default 1000: millisecond ticks per seconds tick in RUN.
REQ-003 Parameter FAST_MS, default 100: millisecond ticks per seconds tick in FAST.
REQ-004 Parameter BLINK_MS, default 250: millisecond ticks per blink half-period.
REQ-005 clk_i  input  1  system clock; all logic is on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start_i  input  1  synchronous pulse; requests counting.
REQ-008 stop_i  input  1  synchronous pulse; requests halt.
REQ-009 fast_i  input  1  synchronous level; requests fast-set rate while counting.
REQ-010 tick_1k_o  output  1  one-cycle millisecond strobe.
REQ-011 sec_tick_o  output  1  one-cycle seconds-advance strobe for the timekeeping datapath.
REQ-012 blink_o  output  1  square wave for setting-mode digit blink.
REQ-013 scan_sel_o  output  2  display digit select, rotating 0..3.
REQ-014 state_o  output  2  current state: STOP=0, RUN=1, FAST=2.

Function
REQ-015 The prescaler SHALL count 0..DIV_1K-1 and wrap; tick_1k_o SHALL be high for exactly one cycle per wrap; the first strobe comes DIV_1K cycles after reset release.
REQ-016 The prescaler, tick_1k_o, blink_o and scan_sel_o SHALL run regardless of state.
REQ-017 scan_sel_o SHALL increment modulo 4 in the cycle after each tick_1k_o.
REQ-018 blink_o SHALL toggle after every BLINK_MS tick_1k_o strobes (50% duty).
REQ-019 FSM transitions SHALL be: STOP->RUN on start_i; RUN->STOP on stop_i; RUN->FAST when fast_i=1; FAST->RUN when fast_i=0; FAST->STOP on stop_i.
REQ-020 stop_i SHALL win when start_i and stop_i are asserted in the same cycle; in STOP that cycle causes no transition.
REQ-021 start_i SHALL be ignored in RUN and FAST; stop_i SHALL be ignored in STOP.
REQ-022 The millisecond accumulator ms_cnt SHALL be held at 0 in STOP.
REQ-023 ms_cnt SHALL be cleared on every state change, so each RUN or FAST entry starts a full interval.
REQ-024 In RUN, sec_tick_o SHALL be asserted in the same cycle as the tick_1k_o that completes MS_PER_SEC strobes, and ms_cnt SHALL wrap to 0.
REQ-025 In FAST, sec_tick_o SHALL be asserted on the tick_1k_o that completes FAST_MS strobes.
REQ-026 sec_tick_o SHALL never be asserted in STOP, or in any cycle in which the state changes.
REQ-027 Counter widths SHALL be derived with clog2 of the parameter values; wrap comparisons SHALL use equality to N-1.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 While reset=0, all counters SHALL be 0, and tick_1k_o=0, sec_tick_o=0, blink_o=0, scan_sel_o=0, state_o=STOP.
REQ-030 Reset asserted mid-interval SHALL abort the interval with no partial strobe; counting restarts from 0 after release.

Structure
REQ-031 State encodings and default parameter constants SHALL live in the shared package clock_pkg.
REQ-032 One sub-module, mod_counter (parameter N, enable in, wrap-strobe out, async active-low reset), SHALL implement the prescaler, the blink counter and ms_cnt.

Verification (DIV_1K=4, MS_PER_SEC=10, FAST_MS=2, BLINK_MS=5)
REQ-033 Release reset, no inputs -> tick_1k_o at cycles 4, 8, 12...; scan_sel_o cycles 0,1,2,3,0; blink_o toggles every 20 cycles; sec_tick_o stays 0.
REQ-034 start_i pulse -> state_o=1; sec_tick_o coincides with the 10th tick_1k_o after entry, then every 40 cycles.
REQ-035 In RUN, raise fast_i -> state_o=2 next cycle; sec_tick_o every 8 cycles; drop fast_i -> state_o=1 and a full 40-cycle interval.
REQ-036 start_i and stop_i in the same cycle while in RUN -> state_o=0; no sec_tick_o afterwards.
REQ-037 stop_i after 7 ms in RUN, then start_i -> first sec_tick_o after 10 full ms, not 3.
REQ-038 Assert reset for 1 cycle mid-FAST -> all outputs reach reset values immediately; state_o=0 after release.
